// File: rtl/npu_param_loader_if.sv
// rtl/npu_param_loader_if.sv - one-word-per-beat parameter stream, weights first then biases
interface npu_param_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/npu_param_loader.sv
// rtl/npu_param_loader.sv - assembles streamed weights/biases in a shadow buffer, commits atomically
function automatic int npl_w_words(input int n, input logic [255:0] sizes);
  int acc;
  acc = 0;
  for (int j = 1; j < n; j++) begin
    acc += int'(sizes[(n-1-j)*8 +: 8]) * int'(sizes[(n-j)*8 +: 8]);
  end
  return acc;
endfunction

function automatic int npl_b_words(input int n, input logic [255:0] sizes);
  int acc;
  acc = 0;
  for (int j = 1; j < n; j++) begin
    acc += int'(sizes[(n-1-j)*8 +: 8]);
  end
  return acc;
endfunction

module npu_param_loader #(
  parameter int                      NUM_LAYERS  = 3,
  parameter logic [8*NUM_LAYERS-1:0] LAYER_SIZES = {8'd4, 8'd4, 8'd4},
  parameter int                      DATA_WIDTH  = 8,
  localparam int W_WORDS = npl_w_words(NUM_LAYERS, 256'(LAYER_SIZES)),
  localparam int B_WORDS = npl_b_words(NUM_LAYERS, 256'(LAYER_SIZES))
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  npu_param_loader_if.slave             s,
  output logic [W_WORDS*DATA_WIDTH-1:0] weights_flat_o,
  output logic [B_WORDS*DATA_WIDTH-1:0] biases_flat_o,
  output logic                          params_valid_o,
  output logic                          commit_pulse_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int TOTAL = W_WORDS + B_WORDS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] W_LAST = CW'(W_WORDS - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, COMMIT} state_t;

  state_t                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic [W_WORDS*DATA_WIDTH-1:0] shadow_w_q;
  logic [B_WORDS*DATA_WIDTH-1:0] shadow_b_q;
  logic [W_WORDS*DATA_WIDTH-1:0] weights_q;
  logic [B_WORDS*DATA_WIDTH-1:0] biases_q;
  logic                          params_valid_q;
  logic                          commit_pulse_q;
  logic                          err_q;
  logic                          accept;

  assign s.s_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign accept    = s.s_valid && s.s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_w_q     <= '0;
      shadow_b_q     <= '0;
      weights_q      <= '0;
      biases_q       <= '0;
      params_valid_q <= 1'b0;
      commit_pulse_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      commit_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD_W;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        LOAD_W: begin
          if (accept) begin
            // Any s_last among the weights is a framing error; abandon the shadow.
            if (s.s_last) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              for (int i = 0; i < W_WORDS; i++) begin
                if (cnt_q == CW'(i)) shadow_w_q[i*DATA_WIDTH +: DATA_WIDTH] <= s.s_data;
              end
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == W_LAST) state_q <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (s.s_last != (cnt_q == T_LAST)) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              for (int i = 0; i < B_WORDS; i++) begin
                if (cnt_q == CW'(W_WORDS + i)) shadow_b_q[i*DATA_WIDTH +: DATA_WIDTH] <= s.s_data;
              end
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == T_LAST) state_q <= COMMIT;
            end
          end
        end
        COMMIT: begin
          weights_q      <= shadow_w_q;
          biases_q       <= shadow_b_q;
          params_valid_q <= 1'b1;
          commit_pulse_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weights_flat_o = weights_q;
  assign biases_flat_o  = biases_q;
  assign params_valid_o = params_valid_q;
  assign commit_pulse_o = commit_pulse_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_npu_param_loader.sv
// tb/tb_npu_param_loader.sv - randomized self-checking bench for npu_param_loader
module tb_npu_param_loader;
  localparam int DW = 8;
  localparam int NW = 32;
  localparam int NB = 8;
  localparam int NT = NW + NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [NW*DW-1:0] weights_flat_o;
  logic [NB*DW-1:0] biases_flat_o;
  logic params_valid_o, commit_pulse_o, busy_o, err_o;

  npu_param_loader_if #(.DATA_WIDTH(DW)) s_if ();

  npu_param_loader #(
    .NUM_LAYERS (3),
    .LAYER_SIZES({8'd4, 8'd4, 8'd4}),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .s             (s_if),
    .weights_flat_o(weights_flat_o),
    .biases_flat_o (biases_flat_o),
    .params_valid_o(params_valid_o),
    .commit_pulse_o(commit_pulse_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    tx_data [NT];
  logic             tx_last [NT];
  logic [NW*DW-1:0] exp_w = '0;
  logic [NB*DW-1:0] exp_b = '0;
  logic             exp_pv = 1'b0;

  function automatic int first_frame_err();
    for (int k = 0; k < NT; k++) begin
      if (tx_last[k] != (k == NT - 1)) return k;
    end
    return -1;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NT; k++) begin
      tx_data[k] = 8'($urandom);
      tx_last[k] = (k == NT - 1);
    end
  endtask

  // gap_mode: 0 continuous, 1 valid toggles every cycle, 2 random gaps
  task automatic run_load(input string name, input int gap_mode, input int restart_at, input int stop_at);
    int ferr, n_send, k, cyc;
    bit restarted;
    logic v, acc;
    ferr = first_frame_err();
    if (stop_at >= 0) n_send = stop_at;
    else if (ferr >= 0) n_send = ferr + 1;
    else n_send = NT;

    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1)
      begin errors++; $display("FAIL %s start: err=%b busy=%b want err=0 busy=1", name, err_o, busy_o); end

    k = 0; cyc = 0; restarted = 0;
    while (k < n_send && cyc < 2000) begin
      case (gap_mode)
        1:       v = (cyc % 2 == 0);
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      s_if.s_valid = v;
      s_if.s_data  = tx_data[k];
      s_if.s_last  = tx_last[k];
      if (k == restart_at && !restarted) begin start_i = 1'b1; restarted = 1; end
      else start_i = 1'b0;
      acc = v && s_if.s_ready;
      @(posedge clk);
      if (acc) k++;
      cyc++;
      @(negedge clk);
    end
    s_if.s_valid = 1'b0; s_if.s_last = 1'b0; s_if.s_data = '0; start_i = 1'b0;
    checks++;
    if (k != n_send) begin errors++; $display("FAIL %s accepted words: got %0d want %0d", name, k, n_send); end
    if (stop_at >= 0) return;

    if (ferr < 0) begin
      checks++;
      if (commit_pulse_o !== 1'b0 || weights_flat_o !== exp_w || biases_flat_o !== exp_b)
        begin errors++; $display("FAIL %s held before commit: pulse=%b w=%h b=%h", name, commit_pulse_o, weights_flat_o, biases_flat_o); end
      for (int j = 0; j < NT; j++) begin
        if (j < NW) exp_w[j*DW +: DW] = tx_data[j];
        else        exp_b[(j-NW)*DW +: DW] = tx_data[j];
      end
      exp_pv = 1'b1;
      @(negedge clk);
      checks++;
      if (commit_pulse_o !== 1'b1) begin errors++; $display("FAIL %s commit_pulse: got %b want 1", name, commit_pulse_o); end
      checks++;
      if (weights_flat_o !== exp_w) begin errors++; $display("FAIL %s weights: got %h want %h", name, weights_flat_o, exp_w); end
      checks++;
      if (biases_flat_o !== exp_b) begin errors++; $display("FAIL %s biases: got %h want %h", name, biases_flat_o, exp_b); end
      checks++;
      if (params_valid_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0)
        begin errors++; $display("FAIL %s status: pv=%b busy=%b err=%b want 1 0 0", name, params_valid_o, busy_o, err_o); end
      @(negedge clk);
      checks++;
      if (commit_pulse_o !== 1'b0) begin errors++; $display("FAIL %s pulse width: got %b want 0", name, commit_pulse_o); end
    end else begin
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0)
        begin errors++; $display("FAIL %s framing: err=%b busy=%b want 1 0", name, err_o, busy_o); end
      checks++;
      if (weights_flat_o !== exp_w || biases_flat_o !== exp_b || params_valid_o !== exp_pv)
        begin errors++; $display("FAIL %s outputs kept: w=%h b=%h pv=%b", name, weights_flat_o, biases_flat_o, params_valid_o); end
      checks++;
      if (commit_pulse_o !== 1'b0) begin errors++; $display("FAIL %s no pulse: got %b want 0", name, commit_pulse_o); end
      @(negedge clk);
      checks++;
      if (commit_pulse_o !== 1'b0 || err_o !== 1'b1)
        begin errors++; $display("FAIL %s after error: pulse=%b err=%b want 0 1", name, commit_pulse_o, err_o); end
    end
  endtask

  task automatic test_reset();
    s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (weights_flat_o !== '0 || biases_flat_o !== '0 || params_valid_o !== 1'b0 ||
        commit_pulse_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || s_if.s_ready !== 1'b0)
      begin errors++; $display("FAIL reset: w=%h b=%h pv=%b cp=%b busy=%b err=%b rdy=%b", weights_flat_o, biases_flat_o,
                               params_valid_o, commit_pulse_o, busy_o, err_o, s_if.s_ready); end
    rst_n = 1'b1;
    s_if.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_if.s_ready !== 1'b0 || busy_o !== 1'b0)
      begin errors++; $display("FAIL idle valid: rdy=%b busy=%b want 0 0", s_if.s_ready, busy_o); end
    s_if.s_valid = 1'b0;
  endtask

  task automatic test_identity();
    for (int k = 0; k < NT; k++) begin
      tx_data[k] = (k < NW && ((k % 16) / 4) == (k % 4)) ? 8'h01 : 8'h00;
      tx_last[k] = (k == NT - 1);
    end
    run_load("identity", 0, -1, -1);
    checks++;
    if (weights_flat_o[7:0] !== 8'h01 || weights_flat_o[15:8] !== 8'h00 || weights_flat_o[175:168] !== 8'h01)
      begin errors++; $display("FAIL identity diag: got %h %h %h want 01 00 01", weights_flat_o[7:0], weights_flat_o[15:8], weights_flat_o[175:168]); end
  endtask

  task automatic test_early_last();
    fill_random();
    tx_last[NT-1] = 1'b0;
    tx_last[10]   = 1'b1;
    run_load("early_last", 0, -1, -1);
    checks++;
    if (weights_flat_o[7:0] !== 8'h01) begin errors++; $display("FAIL early_last kept: got %h want 01", weights_flat_o[7:0]); end
  endtask

  task automatic test_missing_last();
    fill_random();
    tx_last[NT-1] = 1'b0;
    run_load("missing_last", 2, -1, -1);
    fill_random();
    run_load("after_error", 2, -1, -1);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < NT; k++) begin
      tx_data[k] = 8'(k);
      tx_last[k] = (k == NT - 1);
    end
    run_load("backpressure", 1, -1, -1);
    checks++;
    if (biases_flat_o[7:0] !== 8'h20 || biases_flat_o[63:56] !== 8'h27 || weights_flat_o[255:248] !== 8'h1f)
      begin errors++; $display("FAIL backpressure ends: got %h %h %h want 20 27 1f", biases_flat_o[7:0], biases_flat_o[63:56], weights_flat_o[255:248]); end
  endtask

  task automatic test_restart_ignored();
    fill_random();
    run_load("restart", 0, 5, -1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      fill_random();
      if ($urandom_range(0, 3) == 0) begin
        int p;
        p = $urandom_range(0, NT - 1);
        tx_last[p] = ~tx_last[p];
      end
      run_load($sformatf("random%0d", r), 2, -1, -1);
    end
  endtask

  task automatic test_async_reset();
    fill_random();
    run_load("pre_reset", 0, -1, 35);
    checks++;
    if (busy_o !== 1'b1 || s_if.s_ready !== 1'b1)
      begin errors++; $display("FAIL pre_reset loading: busy=%b rdy=%b want 1 1", busy_o, s_if.s_ready); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (weights_flat_o !== '0 || biases_flat_o !== '0 || params_valid_o !== 1'b0 || s_if.s_ready !== 1'b0 ||
        busy_o !== 1'b0 || err_o !== 1'b0 || commit_pulse_o !== 1'b0)
      begin errors++; $display("FAIL async reset: w=%h b=%h pv=%b rdy=%b busy=%b", weights_flat_o, biases_flat_o,
                               params_valid_o, s_if.s_ready, busy_o); end
    exp_w = '0; exp_b = '0; exp_pv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    fill_random();
    run_load("post_reset", 2, -1, -1);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_restart_ignored();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
